fetch_branch_predictor: RTL

- Dynamic gshare branch predictor in the Fetch Unit (FU) of the PQR5 core.
- Predicts taken/not-taken for fetched branch and JAL instructions and hands the Global History Register (GHR) snapshot down the pipeline with each prediction.
- Consumes the resolution updates (GHR shift, Branch History Table (BHT) counter update) returned by the EXU branch unit one cycle after resolution.
- Closes the predict -> resolve -> train loop.

---
 rtl/pqr5_core_pkg.sv | 13 +
 rtl/bp_bht_ram.sv | 46 ++++
 rtl/fetch_branch_predictor.sv | 98 +++++++++
 3 files changed

// File: rtl/pqr5_core_pkg.sv
// Shared PQR5 core definitions: BHT 2-bit counter encoding and branch predictor FSM states.
package pqr5_core_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] BHT_SNT = 2'b00;
  localparam logic [1:0] BHT_WNT = 2'b01;
  localparam logic [1:0] BHT_WT  = 2'b10;
  localparam logic [1:0] BHT_ST  = 2'b11;

  typedef enum logic {BP_INIT, BP_RUN} bp_state_t;

endpackage

// File: rtl/bp_bht_ram.sv
// BHT counter array: one read-modify-write update port, one registered lookup port.
// With BP_WR_BYPASS_EN defined, a lookup hitting the index being trained sees the trained value.
module bp_bht_ram
  import pqr5_core_pkg::*;
#(
  parameter int IDW = 6
) (
  input  logic           clk,
  input  logic           init_en,
  input  logic [IDW-1:0] init_idx,
  input  logic           upd_en,
  input  logic [IDW-1:0] upd_idx,
  input  logic           upd_taken,
  input  logic           rd_en,
  input  logic [IDW-1:0] rd_idx,
  output logic [1:0]     rd_ctr
);

  logic [1:0] mem [0:(1<<IDW)-1];
  logic [1:0] upd_cur;
  logic [1:0] upd_nxt;
  logic [1:0] rd_next;

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic t);
    if (t) return (c == BHT_ST) ? BHT_ST : c + 2'd1;
    else   return (c == BHT_SNT) ? BHT_SNT : c - 2'd1;
  endfunction

  assign upd_cur = mem[upd_idx];
  assign upd_nxt = sat_step(upd_cur, upd_taken);

  always_comb begin
    rd_next = mem[rd_idx];
`ifdef BP_WR_BYPASS_EN
    if (upd_en && (upd_idx == rd_idx)) rd_next = upd_nxt;
`endif
  end

  // Storage is not reset; the owner sweeps it to weak-NT after reset.
  always_ff @(posedge clk) begin
    if (init_en)     mem[init_idx] <= BHT_WNT;
    else if (upd_en) mem[upd_idx]  <= upd_nxt;
    if (rd_en) rd_ctr <= rd_next;
  end

endmodule

// File: rtl/fetch_branch_predictor.sv
// Gshare fetch predictor: GHR xor PC indexes a 2-bit counter BHT, trained by EXU resolutions.
// Optional macro BP_WR_BYPASS_EN (in bp_bht_ram) forwards same-cycle training into the lookup.
module fetch_branch_predictor
  import pqr5_core_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_INIT = '0,
  parameter int              GHRW    = 4,
  parameter int              BHT_IDW = 6,
  parameter int              BPCW    = BHT_IDW + 2
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic              i_stall,
  input  logic              i_lkp_valid,
  input  logic [XLEN-1:0]   i_lkp_pc,
  input  logic              i_lkp_is_branch,
  input  logic              i_lkp_is_jal,
  input  logic              i_upd_ghr,
  input  logic              i_upd_bht,
  input  logic [BPCW-1:0]   i_upd_idx_pc,
  input  logic [GHRW-1:0]   i_upd_idx_ghr,
  input  logic              i_upd_btaken,
  output logic              o_pred_valid,
  output logic              o_pred_taken,
  output logic [XLEN-1:0]   o_pred_pc,
  output logic [GHRW-1:0]   o_ghr_snapshot,
  output logic              o_init_done
);

  bp_state_t          state;
  logic [BHT_IDW-1:0] sweep;
  logic [GHRW-1:0]    ghr;
  logic               br_p1;
  logic               jal_p1;
  logic [1:0]         ctr_p1;
  logic               run;
  logic [BHT_IDW-1:0] lkp_idx;
  logic [BHT_IDW-1:0] upd_idx;
  logic               unused_upd_pc_lo;

  assign run              = (state == BP_RUN);
  assign lkp_idx          = i_lkp_pc[BPCW-1:2] ^ BHT_IDW'(ghr);
  assign upd_idx          = i_upd_idx_pc[BPCW-1:2] ^ BHT_IDW'(i_upd_idx_ghr);
  assign unused_upd_pc_lo = ^i_upd_idx_pc[1:0];

  bp_bht_ram #(.IDW(BHT_IDW)) u_bht (
    .clk       (clk),
    .init_en   (!run),
    .init_idx  (sweep),
    .upd_en    (run && i_upd_bht),
    .upd_idx   (upd_idx),
    .upd_taken (i_upd_btaken),
    .rd_en     (run && !i_stall && i_lkp_valid),
    .rd_idx    (lkp_idx),
    .rd_ctr    (ctr_p1)
  );

  // Lookup stage p1: counter arrives registered from the BHT alongside the captured decode bits.
  assign o_pred_taken = jal_p1 | (br_p1 & ctr_p1[1]);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= BP_INIT;
      sweep          <= '0;
      ghr            <= '0;
      o_init_done    <= 1'b0;
      o_pred_valid   <= 1'b0;
      o_pred_pc      <= PC_INIT;
      o_ghr_snapshot <= '0;
      br_p1          <= 1'b0;
      jal_p1         <= 1'b0;
    end else begin
      case (state)
        BP_INIT: begin
          sweep <= sweep + BHT_IDW'(1);
          if (&sweep) begin
            state       <= BP_RUN;
            o_init_done <= 1'b1;
          end
        end
        BP_RUN: begin
          if (i_upd_ghr) ghr <= {ghr[GHRW-2:0], i_upd_btaken};
          if (!i_stall) begin
            o_pred_valid <= i_lkp_valid;
            if (i_lkp_valid) begin
              o_pred_pc      <= i_lkp_pc;
              o_ghr_snapshot <= ghr;
              br_p1          <= i_lkp_is_branch;
              jal_p1         <= i_lkp_is_jal;
            end
          end
        end
        default: state <= BP_INIT;
      endcase
    end
  end

endmodule
